gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
Memory-mapped general-purpose I/O controller for the rv32 SoC. It sits on the CPU command/response bus, selected by the SoC address decoder for the 4 KB window at 0xF000_0000. It provides output data, output enable, synchronised input sampling, atomic set/clear/toggle, and rising-edge capture for NR_GPIOS pins. The byte-lane program RAM (rv32_program_ram_2048x8) is a separate block and is not covered here.

Parameters:
NR_GPIOS, 8, number of GPIO pins; legal range 1..32.

Ports:
clk  input  1  single clock; all state on rising edge.
reset_  input  1  reset, asynchronous, active-high.
mem_cmd_sel  input  1  address decoder hit for the GPIO window.
mem_cmd_valid  input  1  command valid; always accepted, with no stall.
mem_cmd_wr  input  1  1 = write, 0 = read.
mem_cmd_addr  input  12  byte offset within the window.
mem_cmd_wdata  input  32  write data; always a full word.
mem_rsp_ready  output  1  read-data-valid strobe.
mem_rsp_rdata  output  32  read data.
gpio_oe  output  NR_GPIOS  per-pin output enable.
gpio_do  output  NR_GPIOS  per-pin output value.
gpio_di  input  NR_GPIOS  per-pin input, asynchronous to clk.

Behaviour:
- Access condition: acc = mem_cmd_valid & mem_cmd_sel.
- Decode uses addr[11:2]. addr[1:0] is ignored.
- Bits at and above NR_GPIOS read as 0 and are ignored on write.
- Register map:
  - 0x00 DOUT, RW: drives gpio_do.
  - 0x04 OE, RW: drives gpio_oe.
  - 0x08 DIN, RO: synchronised input.
  - 0x0C SET, WO: DOUT |= wdata.
  - 0x10 CLR, WO: DOUT &= ~wdata.
  - 0x14 TGL, WO: DOUT ^= wdata.
  - 0x18 EDGE, RW1C: sticky rising-edge flags.
- Write-only registers and unmapped offsets read as 0. Writes to DIN and to unmapped offsets are ignored.
- Writes take effect on the clock edge where acc & wr is high. gpio_do and gpio_oe change in the following cycle. Writes produce no response.
- Reads: for acc & !wr in cycle N, mem_rsp_ready = 1 for exactly one cycle in N+1, and mem_rsp_rdata carries the register value sampled at edge N. Back-to-back reads give back-to-back responses.
- mem_rsp_rdata holds its last value when mem_rsp_ready = 0.
- Input path: 2-flop synchroniser on gpio_di to produce din_s, plus a third flop din_d.
  - DIN = din_s.
  - edge = din_s & ~din_d.
  - A pin change appears in DIN 2 cycles after it is sampled.
- EDGE register: each bit sets on edge. Writing 1 clears that bit. If a set and a clear hit the same bit in the same cycle, set wins.
- SET/CLR/TGL are not an RMW race: the update uses the current DOUT.
- Reset values: DOUT = 0, OE = 0 (all pins inputs), EDGE = 0, synchroniser flops = 0, mem_rsp_ready = 0, mem_rsp_rdata = 0.
- Reset asserted mid-transaction drops any pending response; no mem_rsp_ready is issued after reset.
- mem_cmd_valid without mem_cmd_sel has no effect.

Decomposition:
- Shared package gpio_pkg holds the register offset constants (GPIO_DOUT = 0x00 through GPIO_EDGE = 0x18) and the window base 0xF0000 for addr[31:12].
- One natural sub-module: gpio_sync, an N-bit 2-flop synchroniser with edge-detect output. Everything else lives in gpio_ctrl.

Test Plan:
1. Reset check: assert reset_ -> gpio_do = 0, gpio_oe = 0, mem_rsp_ready = 0. After release, read 0x00 -> rdata 0x0000_0000 with ready exactly one cycle later.
2. Output and enable: write 0x04 = 0xFF, then 0x00 = 0xA5 -> gpio_oe = 0xFF, gpio_do = 0xA5 next cycle. Write 0x00 = 0xFFFF_FF5A -> reading 0x00 returns 0x0000_005A.
3. Atomic ops starting from DOUT = 0xA5:
   - SET 0x0A -> 0xAF.
   - CLR 0x81 -> 0x2E.
   - TGL 0xFF -> 0xD1.
   - Back-to-back writes in consecutive cycles all apply.
4. Input sync: drive gpio_di = 0x3C -> reading 0x08 reflects 0x3C only from the 3rd edge onward. Drive 0x3C->0x00->0x01 -> EDGE reads 0x3D. Write EDGE 0x3C -> EDGE reads 0x01.
5. Bus corner cases:
   - Read with mem_cmd_sel = 0 -> no ready.
   - Read 0x0C or 0x100 -> rdata 0, ready issued.
   - Write to 0x08 -> no change.
   - Reads at 0x01 and 0x03 alias 0x00.
   - Reset asserted the cycle after a read -> no ready pulse.

Source files
------------

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Register map, window base and decode helper for gpio_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

   localparam logic [19:0] GPIO_BASE = 20'hF0000;

   localparam logic [11:0] GPIO_DOUT = 12'h000;
   localparam logic [11:0] GPIO_OE   = 12'h004;
   localparam logic [11:0] GPIO_DIN  = 12'h008;
   localparam logic [11:0] GPIO_SET  = 12'h00C;
   localparam logic [11:0] GPIO_CLR  = 12'h010;
   localparam logic [11:0] GPIO_TGL  = 12'h014;
   localparam logic [11:0] GPIO_EDGE = 12'h018;

   typedef enum logic [2:0] {
      REG_DOUT = 3'd0,
      REG_OE   = 3'd1,
      REG_DIN  = 3'd2,
      REG_SET  = 3'd3,
      REG_CLR  = 3'd4,
      REG_TGL  = 3'd5,
      REG_EDGE = 3'd6,
      REG_NONE = 3'd7
   } gpio_reg_e;

   // Takes the word index (byte offset bits 11:2); byte-within-word is never decoded.
   function automatic gpio_reg_e gpio_decode(input logic [9:0] word);
      gpio_reg_e r;
      case (word)
         GPIO_DOUT[11:2]: r = REG_DOUT;
         GPIO_OE[11:2]:   r = REG_OE;
         GPIO_DIN[11:2]:  r = REG_DIN;
         GPIO_SET[11:2]:  r = REG_SET;
         GPIO_CLR[11:2]:  r = REG_CLR;
         GPIO_TGL[11:2]:  r = REG_TGL;
         GPIO_EDGE[11:2]: r = REG_EDGE;
         default:         r = REG_NONE;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_if
// Description : CPU command/response bus as seen by the GPIO window.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_if;

   logic        mem_cmd_sel;
   logic        mem_cmd_valid;
   logic        mem_cmd_wr;
   logic [11:0] mem_cmd_addr;
   logic [31:0] mem_cmd_wdata;
   logic        mem_rsp_ready;
   logic [31:0] mem_rsp_rdata;

   modport master (
      output mem_cmd_sel, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata,
      input  mem_rsp_ready, mem_rsp_rdata
   );

   modport slave (
      input  mem_cmd_sel, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata,
      output mem_rsp_ready, mem_rsp_rdata
   );

endinterface
`default_nettype wire

// File: rtl/gpio_sync.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sync
// Description : N-bit 2-flop synchroniser with a delayed copy for rise detect.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise_out
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] r_dly;

   always_ff @(posedge clk or posedge reset_) begin
      if (reset_) begin
         r_meta <= '0;
         r_sync <= '0;
         r_dly  <= '0;
      end else begin
         r_meta <= async_in;
         r_sync <= r_meta;
         r_dly  <= r_sync;
      end
   end

   assign sync_out = r_sync;
   assign rise_out = r_sync & ~r_dly;

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_ctrl
// Description : Memory-mapped GPIO: DOUT/OE, synchronised DIN, SET/CLR/TGL, EDGE.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_ctrl
   import gpio_pkg::*;
#(
   parameter int NR_GPIOS = 8
) (
   input  logic                clk,
   input  logic                reset_,
   gpio_if.slave               bus,
   output logic [NR_GPIOS-1:0] gpio_oe,
   output logic [NR_GPIOS-1:0] gpio_do,
   input  logic [NR_GPIOS-1:0] gpio_di
);

   logic                w_acc;
   logic                w_rd;
   logic                w_wr;
   gpio_reg_e           w_reg;
   logic [NR_GPIOS-1:0] w_wdata;
   logic [NR_GPIOS-1:0] w_din_s;
   logic [NR_GPIOS-1:0] w_rise;
   logic [NR_GPIOS-1:0] w_dout_nxt;
   logic [NR_GPIOS-1:0] w_edge_clr;
   logic [31:0]         w_rdata;
   logic                w_unused_bits;

   logic [NR_GPIOS-1:0] r_dout;
   logic [NR_GPIOS-1:0] r_oe;
   logic [NR_GPIOS-1:0] r_edge;
   logic                r_rsp_ready;
   logic [31:0]         r_rsp_rdata;

   gpio_sync #(.WIDTH(NR_GPIOS)) u_sync (
      .clk      (clk),
      .reset_   (reset_),
      .async_in (gpio_di),
      .sync_out (w_din_s),
      .rise_out (w_rise)
   );

   assign w_acc   = bus.mem_cmd_valid & bus.mem_cmd_sel;
   assign w_rd    = w_acc & ~bus.mem_cmd_wr;
   assign w_wr    = w_acc &  bus.mem_cmd_wr;
   assign w_reg   = gpio_decode(bus.mem_cmd_addr[11:2]);
   assign w_wdata = bus.mem_cmd_wdata[NR_GPIOS-1:0];

   assign w_unused_bits = ^{bus.mem_cmd_addr[1:0], bus.mem_cmd_wdata};

   always_comb begin
      w_rdata = '0;
      case (w_reg)
         REG_DOUT: w_rdata[NR_GPIOS-1:0] = r_dout;
         REG_OE:   w_rdata[NR_GPIOS-1:0] = r_oe;
         REG_DIN:  w_rdata[NR_GPIOS-1:0] = w_din_s;
         REG_EDGE: w_rdata[NR_GPIOS-1:0] = r_edge;
         default:  w_rdata = '0;
      endcase
   end

   // Atomic ops read the live DOUT, so consecutive SET/CLR/TGL compose cleanly.
   always_comb begin
      w_dout_nxt = r_dout;
      if (w_wr) begin
         case (w_reg)
            REG_DOUT: w_dout_nxt = w_wdata;
            REG_SET:  w_dout_nxt = r_dout | w_wdata;
            REG_CLR:  w_dout_nxt = r_dout & ~w_wdata;
            REG_TGL:  w_dout_nxt = r_dout ^ w_wdata;
            default:  w_dout_nxt = r_dout;
         endcase
      end
   end

   assign w_edge_clr = (w_wr && (w_reg == REG_EDGE)) ? w_wdata : '0;

   always_ff @(posedge clk or posedge reset_) begin
      if (reset_) begin
         r_dout      <= '0;
         r_oe        <= '0;
         r_edge      <= '0;
         r_rsp_ready <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_dout      <= w_dout_nxt;
         if (w_wr && (w_reg == REG_OE))
            r_oe <= w_wdata;
         // OR-ing the rise after the clear lets a same-cycle edge survive a W1C.
         r_edge      <= (r_edge & ~w_edge_clr) | w_rise;
         r_rsp_ready <= w_rd;
         if (w_rd)
            r_rsp_rdata <= w_rdata;
      end
   end

   assign bus.mem_rsp_ready = r_rsp_ready;
   assign bus.mem_rsp_rdata = r_rsp_rdata;
   assign gpio_do           = r_dout;
   assign gpio_oe           = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_ctrl
// Description : Vector table plus hand sequences, checked through a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl;
   import gpio_pkg::*;

   typedef struct {
      logic        valid;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_ready;
      logic [31:0] exp_rdata;
      logic [7:0]  exp_do;
      logic [7:0]  exp_oe;
   } vec_t;

   typedef struct {
      logic        exp_ready;
      logic [31:0] exp_rdata;
      logic [7:0]  exp_do;
      logic [7:0]  exp_oe;
      int          id;
   } exp_t;

   logic       clk;
   logic       reset_;
   logic [7:0] gpio_oe;
   logic [7:0] gpio_do;
   logic [7:0] gpio_di;
   logic [7:0] di_next;

   int          n_chk;
   int          n_pass;
   logic [31:0] last_rdata;
   exp_t        sb[$];
   vec_t        tbl[$];
   exp_t        e;

   gpio_if bus ();

   gpio_ctrl #(.NR_GPIOS(8)) dut (
      .clk     (clk),
      .reset_  (reset_),
      .bus     (bus),
      .gpio_oe (gpio_oe),
      .gpio_do (gpio_do),
      .gpio_di (gpio_di)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ga(input logic [11:0] off);
      return {GPIO_BASE, off};
   endfunction

   function automatic vec_t mk(input logic v, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic er, input logic [31:0] erd,
                               input logic [7:0] edo, input logic [7:0] eoe);
      vec_t t;
      t.valid = v; t.wr = w; t.addr = a; t.wdata = wd;
      t.exp_ready = er; t.exp_rdata = erd; t.exp_do = edo; t.exp_oe = eoe;
      return t;
   endfunction

   task automatic chk(input logic [31:0] act, input logic [31:0] exp,
                      input logic [8*8-1:0] nm, input int id);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %0s id=%0d actual=%h expected=%h", nm, id, act, exp);
   endtask

   // One bus cycle: drive at the falling edge and queue what the next rising edge must yield.
   task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic er, input logic [31:0] erd,
                        input logic [7:0] edo, input logic [7:0] eoe, input int id);
      exp_t x;
      @(negedge clk);
      gpio_di           = di_next;
      bus.mem_cmd_valid = v;
      bus.mem_cmd_wr    = w;
      bus.mem_cmd_sel   = (a[31:12] == GPIO_BASE);
      bus.mem_cmd_addr  = a[11:0];
      bus.mem_cmd_wdata = wd;
      x.exp_ready = er; x.exp_rdata = erd; x.exp_do = edo; x.exp_oe = eoe; x.id = id;
      sb.push_back(x);
   endtask

   task automatic idle(input logic [7:0] edo, input logic [7:0] eoe, input int id);
      drive(1'b0, 1'b0, ga(GPIO_DOUT), 32'h0, 1'b0, 32'h0, edo, eoe, id);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({31'b0, bus.mem_rsp_ready}, {31'b0, e.exp_ready}, "ready", e.id);
         if (e.exp_ready) begin
            chk(bus.mem_rsp_rdata, e.exp_rdata, "rdata", e.id);
            last_rdata = e.exp_rdata;
         end else begin
            chk(bus.mem_rsp_rdata, last_rdata, "hold", e.id);
         end
         chk({24'b0, gpio_do}, {24'b0, e.exp_do}, "gpio_do", e.id);
         chk({24'b0, gpio_oe}, {24'b0, e.exp_oe}, "gpio_oe", e.id);
      end else if (bus.mem_rsp_ready) begin
         chk({31'b0, bus.mem_rsp_ready}, 32'h0, "spurious", -1);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d passed=%0d", n_chk, n_pass);
      $fatal(1, "timeout");
   end

   initial begin
      n_chk = 0; n_pass = 0; last_rdata = 32'h0;
      di_next = 8'h00; gpio_di = 8'h00;
      bus.mem_cmd_valid = 1'b0; bus.mem_cmd_sel = 1'b0; bus.mem_cmd_wr = 1'b0;
      bus.mem_cmd_addr = 12'h0; bus.mem_cmd_wdata = 32'h0;
      reset_ = 1'b1;

      repeat (3) @(negedge clk);
      chk({24'b0, gpio_do}, 32'h0, "rst_do", 0);
      chk({24'b0, gpio_oe}, 32'h0, "rst_oe", 0);
      chk({31'b0, bus.mem_rsp_ready}, 32'h0, "rst_rdy", 0);
      chk(bus.mem_rsp_rdata, 32'h0, "rst_rd", 0);
      reset_ = 1'b0;

      tbl.push_back(mk(1, 0, ga(GPIO_DOUT), 32'h0,         1, 32'h00, 8'h00, 8'h00));
      tbl.push_back(mk(1, 1, ga(GPIO_OE),   32'hFF,        0, 32'h00, 8'h00, 8'hFF));
      tbl.push_back(mk(1, 1, ga(GPIO_DOUT), 32'hA5,        0, 32'h00, 8'hA5, 8'hFF));
      tbl.push_back(mk(1, 0, ga(GPIO_OE),   32'h0,         1, 32'hFF, 8'hA5, 8'hFF));
      tbl.push_back(mk(1, 1, ga(GPIO_DOUT), 32'hFFFF_FF5A, 0, 32'h00, 8'h5A, 8'hFF));
      tbl.push_back(mk(1, 0, ga(GPIO_DOUT), 32'h0,         1, 32'h5A, 8'h5A, 8'hFF));
      tbl.push_back(mk(1, 1, ga(GPIO_DOUT), 32'hA5,        0, 32'h00, 8'hA5, 8'hFF));
      tbl.push_back(mk(1, 1, ga(GPIO_SET),  32'h0A,        0, 32'h00, 8'hAF, 8'hFF));
      tbl.push_back(mk(1, 1, ga(GPIO_CLR),  32'h81,        0, 32'h00, 8'h2E, 8'hFF));
      tbl.push_back(mk(1, 1, ga(GPIO_TGL),  32'hFF,        0, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 0, ga(GPIO_DOUT), 32'h0,         1, 32'hD1, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 0, ga(GPIO_SET),  32'h0,         1, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 0, ga(12'h100),   32'h0,         1, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 0, ga(GPIO_CLR),  32'h0,         1, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 0, ga(GPIO_TGL),  32'h0,         1, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 1, ga(GPIO_DIN),  32'h55,        0, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 0, ga(12'h001),   32'h0,         1, 32'hD1, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 0, ga(12'h003),   32'h0,         1, 32'hD1, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 0, 32'hE000_0000, 32'h0,         0, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 1, 32'hE000_0000, 32'h0,         0, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 1, ga(12'h100),   32'h0,         0, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 1, ga(12'h01C),   32'h0,         0, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 0, ga(GPIO_DIN),  32'h0,         1, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 0, ga(GPIO_EDGE), 32'h0,         1, 32'h00, 8'hD1, 8'hFF));
      tbl.push_back(mk(1, 1, ga(GPIO_OE),   32'h0F,        0, 32'h00, 8'hD1, 8'h0F));
      tbl.push_back(mk(1, 0, ga(GPIO_OE),   32'h0,         1, 32'h0F, 8'hD1, 8'h0F));
      tbl.push_back(mk(1, 1, ga(GPIO_OE),   32'hFFFF_FF00, 0, 32'h00, 8'hD1, 8'h00));
      tbl.push_back(mk(0, 1, ga(GPIO_DOUT), 32'h0,         0, 32'h00, 8'hD1, 8'h00));
      tbl.push_back(mk(1, 0, ga(GPIO_DOUT), 32'h0,         1, 32'hD1, 8'hD1, 8'h00));
      tbl.push_back(mk(1, 1, ga(GPIO_SET),  32'hFFFF_FF00, 0, 32'h00, 8'hD1, 8'h00));

      foreach (tbl[i])
         drive(tbl[i].valid, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
               tbl[i].exp_ready, tbl[i].exp_rdata, tbl[i].exp_do, tbl[i].exp_oe, i);

      // DIN becomes visible to a read sampled on the third edge after the pin change.
      di_next = 8'h3C;
      drive(1, 0, ga(GPIO_DIN),  0, 1, 32'h00, 8'hD1, 8'h00, 100);
      drive(1, 0, ga(GPIO_DIN),  0, 1, 32'h00, 8'hD1, 8'h00, 101);
      drive(1, 0, ga(GPIO_DIN),  0, 1, 32'h3C, 8'hD1, 8'h00, 102);
      drive(1, 0, ga(GPIO_EDGE), 0, 1, 32'h3C, 8'hD1, 8'h00, 103);
      di_next = 8'h00;
      for (int k = 0; k < 3; k++) idle(8'hD1, 8'h00, 104);
      di_next = 8'h01;
      for (int k = 0; k < 3; k++) idle(8'hD1, 8'h00, 105);
      drive(1, 0, ga(GPIO_EDGE), 0,     1, 32'h3D, 8'hD1, 8'h00, 106);
      drive(1, 0, ga(GPIO_DIN),  0,     1, 32'h01, 8'hD1, 8'h00, 107);
      drive(1, 1, ga(GPIO_EDGE), 32'h3C, 0, 32'h00, 8'hD1, 8'h00, 108);
      drive(1, 0, ga(GPIO_EDGE), 0,     1, 32'h01, 8'hD1, 8'h00, 109);
      drive(1, 1, ga(GPIO_EDGE), 32'h01, 0, 32'h00, 8'hD1, 8'h00, 110);
      drive(1, 0, ga(GPIO_EDGE), 0,     1, 32'h00, 8'hD1, 8'h00, 111);

      // A W1C landing on the same edge as a fresh rise must leave the flag set.
      di_next = 8'h00;
      for (int k = 0; k < 3; k++) idle(8'hD1, 8'h00, 112);
      di_next = 8'h01;
      idle(8'hD1, 8'h00, 113);
      idle(8'hD1, 8'h00, 114);
      drive(1, 1, ga(GPIO_EDGE), 32'h01, 0, 32'h00, 8'hD1, 8'h00, 115);
      drive(1, 0, ga(GPIO_EDGE), 0,     1, 32'h01, 8'hD1, 8'h00, 116);
      drive(1, 1, ga(GPIO_EDGE), 32'h01, 0, 32'h00, 8'hD1, 8'h00, 117);
      drive(1, 0, ga(GPIO_EDGE), 0,     1, 32'h00, 8'hD1, 8'h00, 118);

      // Reset lands before the edge that would have issued the response.
      drive(1, 0, ga(GPIO_DOUT), 0, 0, 32'h00, 8'h00, 8'h00, 200);
      #2;
      reset_ = 1'b1;
      last_rdata = 32'h0;
      @(negedge clk);
      reset_ = 1'b0;
      bus.mem_cmd_valid = 1'b0;
      idle(8'h00, 8'h00, 201);
      drive(1, 0, ga(GPIO_DOUT), 0, 1, 32'h00, 8'h00, 8'h00, 202);
      drive(1, 0, ga(GPIO_OE),   0, 1, 32'h00, 8'h00, 8'h00, 203);
      idle(8'h00, 8'h00, 204);

      repeat (2) @(posedge clk);
      #2;
      chk(sb.size(), 32'h0, "drain", 300);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
